// File: rtl/mlp_pkg.sv
// Shared definitions for the O/X-detecting MLP: datapath widths, training targets,
// sequencer states and the saturate-to-W helper used across the datapath blocks.
package mlp_pkg;

  localparam int W      = 8;
  localparam int FRAC   = 4;
  localparam int HRAW_W = W + 5;

  localparam int TGT_O = 32;
  localparam int TGT_X = -32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD,
    ST_WAIT,
    ST_ERR,
    ST_LEARN,
    ST_NEXT
  } state_t;

  // Clamp a wide signed value into the signed W-bit range.
  function automatic logic signed [W-1:0] sat_w(input logic signed [HRAW_W-1:0] v);
    logic signed [HRAW_W-1:0] hi;
    logic signed [HRAW_W-1:0] lo;
    hi = HRAW_W'((1 << (W - 1)) - 1);
    lo = -hi - 1'b1;
    if (v > hi)      return hi[W-1:0];
    else if (v < lo) return lo[W-1:0];
    else             return v[W-1:0];
  endfunction

endpackage

// File: rtl/mlp_sample_mem.sv
// Labelled sample buffer: synchronous write, combinational read, contents never reset.
module mlp_sample_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 17
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/mlp_train_ctrl.sv
// Training sequencer: steps buffered samples through the forward pass, derives a
// saturated error per sample, strobes the update block and tracks per-epoch accuracy.
module mlp_train_ctrl
  import mlp_pkg::*;
#(
  parameter int W     = mlp_pkg::W,
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int EPW   = 8,
  parameter int TGT_O = mlp_pkg::TGT_O,
  parameter int TGT_X = mlp_pkg::TGT_X
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [15:0]         wr_x,
  input  logic                wr_label,
  input  logic [AW:0]         cfg_n,
  input  logic [EPW-1:0]      cfg_epochs,
  input  logic                start,
  input  logic                abort,
  output logic                fwd_start,
  output logic [15:0]         fwd_x,
  input  logic                fwd_done,
  input  logic signed [W-1:0] fwd_y,
  output logic                learn,
  output logic [15:0]         x,
  output logic signed [W-1:0] err,
  output logic                busy,
  output logic                done,
  output logic [EPW-1:0]      epoch_cnt,
  output logic [AW:0]         correct_cnt,
  output logic                epoch_pulse,
  output logic [AW:0]         last_correct
);

  state_t              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [AW:0]         n_q, n_d;
  logic [EPW-1:0]      epochs_q, epochs_d;
  logic signed [W-1:0] y_q, y_d;
  logic signed [W-1:0] err_q, err_d;
  logic [15:0]         fwd_x_q, fwd_x_d;
  logic                fwd_start_q, fwd_start_d;
  logic                learn_q, learn_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                epoch_pulse_q, epoch_pulse_d;
  logic [EPW-1:0]      epoch_cnt_q, epoch_cnt_d;
  logic [AW:0]         correct_q, correct_d;
  logic [AW:0]         last_correct_q, last_correct_d;

  logic                wr_ok;
  logic [AW-1:0]       rd_addr;
  logic [16:0]         rd_data;
  logic [15:0]         rd_x;
  logic                label;
  logic signed [W:0]   tgt;
  logic signed [W:0]   diff;
  logic signed [HRAW_W-1:0] diff_ext;
  logic signed [W-1:0] err_sat;
  logic                is_correct;

  assign wr_ok = wr_en && (state_q == ST_IDLE);
  // Idle reads slot 0 so the first FWD can load its pixels on the start edge.
  assign rd_addr = (state_q == ST_IDLE) ? '0 : idx_q;

  mlp_sample_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (17)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data ({wr_label, wr_x}),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // A write coinciding with start must be visible to the first sample.
  assign rd_x  = (wr_ok && (wr_addr == rd_addr)) ? wr_x : rd_data[15:0];
  assign label = rd_data[16];

  assign tgt        = label ? (W+1)'(TGT_O) : (W+1)'(TGT_X);
  assign diff       = tgt - $signed({y_q[W-1], y_q});
  assign diff_ext   = {{(HRAW_W-W-1){diff[W]}}, diff};
  assign err_sat    = sat_w(diff_ext);
  assign is_correct = (!y_q[W-1]) == label;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    n_d            = n_q;
    epochs_d       = epochs_q;
    y_d            = y_q;
    err_d          = err_q;
    fwd_x_d        = fwd_x_q;
    done_d         = 1'b0;
    epoch_pulse_d  = 1'b0;
    epoch_cnt_d    = epoch_cnt_q;
    correct_d      = correct_q;
    last_correct_d = last_correct_q;

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            n_d         = cfg_n;
            epochs_d    = cfg_epochs;
            idx_d       = '0;
            epoch_cnt_d = '0;
            correct_d   = '0;
            if ((cfg_n == '0) || (cfg_epochs == '0)) done_d  = 1'b1;
            else                                     state_d = ST_FWD;
          end
        end
        ST_FWD:  state_d = ST_WAIT;
        ST_WAIT: begin
          if (fwd_done) begin
            y_d     = fwd_y;
            state_d = ST_ERR;
          end
        end
        ST_ERR: begin
          err_d = err_sat;
          if (is_correct) correct_d = correct_q + 1'b1;
          state_d = (err_sat == '0) ? ST_NEXT : ST_LEARN;
        end
        ST_LEARN: state_d = ST_NEXT;
        ST_NEXT:  state_d = done_q ? ST_IDLE : ST_FWD;
        default:  state_d = ST_IDLE;
      endcase

      // Epoch bookkeeping happens on entry to NEXT so the pulses coincide with it.
      if ((state_d == ST_NEXT) && (state_q != ST_NEXT)) begin
        if ({1'b0, idx_q} == (n_q - 1'b1)) begin
          epoch_pulse_d  = 1'b1;
          last_correct_d = correct_d;
          correct_d      = '0;
          epoch_cnt_d    = epoch_cnt_q + 1'b1;
          idx_d          = '0;
          done_d         = ((epoch_cnt_q + 1'b1) == epochs_q);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      if ((state_d == ST_FWD) && (state_q != ST_FWD)) fwd_x_d = rd_x;
    end

    fwd_start_d = (state_d == ST_FWD);
    learn_d     = (state_d == ST_LEARN);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      n_q            <= '0;
      epochs_q       <= '0;
      y_q            <= '0;
      err_q          <= '0;
      fwd_x_q        <= '0;
      fwd_start_q    <= 1'b0;
      learn_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      epoch_pulse_q  <= 1'b0;
      epoch_cnt_q    <= '0;
      correct_q      <= '0;
      last_correct_q <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      n_q            <= n_d;
      epochs_q       <= epochs_d;
      y_q            <= y_d;
      err_q          <= err_d;
      fwd_x_q        <= fwd_x_d;
      fwd_start_q    <= fwd_start_d;
      learn_q        <= learn_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      epoch_pulse_q  <= epoch_pulse_d;
      epoch_cnt_q    <= epoch_cnt_d;
      correct_q      <= correct_d;
      last_correct_q <= last_correct_d;
    end
  end

  assign fwd_start    = fwd_start_q;
  assign fwd_x        = fwd_x_q;
  assign x            = fwd_x_q;
  assign learn        = learn_q;
  assign err          = err_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign epoch_pulse  = epoch_pulse_q;
  assign epoch_cnt    = epoch_cnt_q;
  assign correct_cnt  = correct_q;
  assign last_correct = last_correct_q;

endmodule

// File: tb/tb_mlp_train_ctrl.sv
// Bench for mlp_train_ctrl: acts as the forward block, predicts every learn strobe,
// epoch result and completion time from the training rules.
module tb_mlp_train_ctrl;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [3:0]        wr_addr = '0;
  logic [15:0]       wr_x = '0;
  logic              wr_label = 1'b0;
  logic [4:0]        cfg_n = '0;
  logic [7:0]        cfg_epochs = '0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              fwd_start;
  logic [15:0]       fwd_x;
  logic              fwd_done = 1'b0;
  logic signed [7:0] fwd_y = '0;
  logic              learn;
  logic [15:0]       x;
  logic signed [7:0] err;
  logic              busy;
  logic              done;
  logic [7:0]        epoch_cnt;
  logic [4:0]        correct_cnt;
  logic              epoch_pulse;
  logic [4:0]        last_correct;

  mlp_train_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_x         (wr_x),
    .wr_label     (wr_label),
    .cfg_n        (cfg_n),
    .cfg_epochs   (cfg_epochs),
    .start        (start),
    .abort        (abort),
    .fwd_start    (fwd_start),
    .fwd_x        (fwd_x),
    .fwd_done     (fwd_done),
    .fwd_y        (fwd_y),
    .learn        (learn),
    .x            (x),
    .err          (err),
    .busy         (busy),
    .done         (done),
    .epoch_cnt    (epoch_cnt),
    .correct_cnt  (correct_cnt),
    .epoch_pulse  (epoch_pulse),
    .last_correct (last_correct)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ticks   = 0;
  int mdl_x [16];
  bit mdl_l [16];
  int y_tab [64];
  int k_tab [64];

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ticks++;
  endtask

  function automatic int sat8(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic check_reset_outputs();
    check("rst fwd_start", fwd_start, 0);
    check("rst learn", learn, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst epoch_pulse", epoch_pulse, 0);
    check("rst fwd_x", fwd_x, 0);
    check("rst x", x, 0);
    check("rst err", $signed(err), 0);
    check("rst epoch_cnt", epoch_cnt, 0);
    check("rst correct_cnt", correct_cnt, 0);
    check("rst last_correct", last_correct, 0);
  endtask

  task automatic check_abort(input int ep_done);
    check("abort busy", busy, 0);
    check("abort fwd_start", fwd_start, 0);
    check("abort learn", learn, 0);
    check("abort epoch_cnt", epoch_cnt, ep_done);
    repeat (3) begin
      tick();
      check("post-abort fwd_start", fwd_start, 0);
      check("post-abort learn", learn, 0);
    end
  endtask

  task automatic wr_sample(input int a, input int xv, input bit l);
    wr_en = 1'b1; wr_addr = a[3:0]; wr_x = xv[15:0]; wr_label = l;
    tick();
    wr_en = 1'b0;
    mdl_x[a] = xv & 16'hFFFF;
    mdl_l[a] = l;
  endtask

  task automatic fill_rand(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      y_tab[i] = int'($urandom_range(0, 255)) - 128;
      k_tab[i] = int'($urandom_range(1, 4));
    end
  endtask

  // mode: 0 full run, 1 abort in first WAIT of sample `at`, 2 abort in its LEARN,
  // 3 reset in its LEARN. wr0 writes slot 0 in the same cycle as start.
  task automatic run(input int n, input int ep, input int mode, input int at, input bit wr0);
    int s, lat, ccnt, k, y, ev, tgt;
    bit last, fin;
    s = 0; lat = 0; ccnt = 0;
    cfg_n = n[4:0]; cfg_epochs = ep[7:0]; start = 1'b1;
    if (wr0) begin
      wr_en = 1'b1; wr_addr = '0; wr_x = 16'($urandom); wr_label = 1'($urandom_range(0, 1));
      mdl_x[0] = int'(wr_x); mdl_l[0] = wr_label;
    end
    ticks = 0;
    tick();
    start = 1'b0; wr_en = 1'b0;
    if (n == 0 || ep == 0) begin
      check("empty done", done, 1);
      check("empty busy", busy, 0);
      check("empty fwd_start", fwd_start, 0);
      tick();
      check("empty done drop", done, 0);
      check("empty fwd_start later", fwd_start, 0);
      $display("[TB] run n=%0d ep=%0d: immediate done", n, ep);
      return;
    end
    for (int e = 0; e < ep; e++) begin
      for (int i = 0; i < n; i++) begin
        check("fwd_start", fwd_start, 1);
        check("fwd_x", fwd_x, mdl_x[i]);
        check("busy", busy, 1);
        k = k_tab[s]; y = y_tab[s];
        fwd_done = 1'($urandom_range(0, 1));
        fwd_y = 8'($urandom);
        tick();
        for (int j = 1; j <= k; j++) begin
          if (mode == 1 && s == at) begin
            fwd_done = 1'b0; abort = 1'b1;
            tick();
            abort = 1'b0;
            check_abort(e);
            $display("[TB] run n=%0d ep=%0d: aborted in WAIT at sample %0d", n, ep, s);
            return;
          end
          fwd_done = (j == k); fwd_y = 8'(y);
          wr_en = 1'($urandom_range(0, 1)); wr_addr = 4'($urandom);
          wr_x = 16'($urandom); wr_label = 1'($urandom_range(0, 1));
          start = 1'($urandom_range(0, 1));
          tick();
        end
        fwd_done = 1'b0; wr_en = 1'b0; start = 1'b0;
        check("err-state learn", learn, 0);
        tgt = mdl_l[i] ? 32 : -32;
        ev  = sat8(tgt - y);
        if ((y >= 0) == mdl_l[i]) ccnt++;
        lat += k + ((ev != 0) ? 4 : 3);
        tick();
        if (ev != 0) begin
          check("learn", learn, 1);
          check("learn err", $signed(err), ev);
          check("learn x", x, mdl_x[i]);
          if (mode == 2 && s == at) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check_abort(e);
            $display("[TB] run n=%0d ep=%0d: aborted in LEARN at sample %0d", n, ep, s);
            return;
          end
          if (mode == 3 && s == at) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            check_reset_outputs();
            $display("[TB] run n=%0d ep=%0d: reset in LEARN at sample %0d", n, ep, s);
            return;
          end
          tick();
        end
        last = (i == n - 1);
        fin  = last && (e == ep - 1);
        check("next learn", learn, 0);
        check("next err", $signed(err), ev);
        check("epoch_pulse", epoch_pulse, int'(last));
        check("done", done, int'(fin));
        if (last) begin
          check("last_correct", last_correct, ccnt);
          check("epoch_cnt", epoch_cnt, e + 1);
          ccnt = 0;
        end
        if (fin) check("done latency", ticks, lat);
        tick();
        s++;
      end
    end
    check("end busy", busy, 0);
    check("end done", done, 0);
    check("end epoch_cnt", epoch_cnt, ep);
    $display("[TB] run n=%0d ep=%0d: %0d samples, done after %0d cycles", n, ep, s, lat);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    check_reset_outputs();
    rst_n = 1'b1;
    tick();

    for (int a = 0; a < 16; a++)
      wr_sample(a, int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));

    // Basic loop: errors 22 and -37, one correct, done 14 cycles after start.
    wr_sample(0, 'hF99F, 1'b1);
    wr_sample(1, 'h9669, 1'b0);
    y_tab[0] = 10; y_tab[1] = 5; k_tab[0] = 3; k_tab[1] = 3;
    run(2, 1, 0, 0, 1'b0);

    // Saturation at both rails.
    wr_sample(0, 'h1234, 1'b0);
    wr_sample(1, 'h4321, 1'b1);
    y_tab[0] = 127; y_tab[1] = -128; k_tab[0] = 1; k_tab[1] = 2;
    run(2, 1, 0, 0, 1'b0);

    // Zero error skips LEARN.
    wr_sample(0, 'hAAAA, 1'b1);
    y_tab[0] = 32; k_tab[0] = 2;
    run(1, 1, 0, 0, 1'b0);

    run(0, 2, 0, 0, 1'b0);
    run(3, 0, 0, 0, 1'b0);

    // Full buffer, three epochs.
    fill_rand(48);
    run(16, 3, 0, 0, 1'b0);

    // Abort in WAIT during the second epoch.
    fill_rand(8);
    run(1, 3, 1, 1, 1'b0);

    // Abort in LEARN.
    y_tab[0] = 0; y_tab[1] = 0; k_tab[0] = 1; k_tab[1] = 1;
    run(2, 1, 2, 1, 1'b0);

    // Reset in LEARN, then rerun the same forward results.
    fill_rand(4);
    y_tab[0] = -7;
    run(2, 1, 3, 0, 1'b0);
    run(2, 1, 0, 0, 1'b0);

    repeat (6) begin
      fill_rand(16);
      run(int'($urandom_range(1, 8)), int'($urandom_range(1, 2)), 0, 0, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mlp_train_ctrl.md
# mlp_train_ctrl

Training sequencer for the on-chip O/X-detecting MLP. It holds a small buffer of labelled 16-pixel samples and runs them through the forward datapath for a configured number of epochs. For each sample it derives a saturated signed error and issues a single-cycle `learn` strobe with a stable `x`/`err` pair to the backprop/update block. It sits between the host/config logic and the forward + update datapath, and reports per-epoch accuracy.

## Interface
- `W`, 8: datapath width; matches the forward output and update `err` width.
- `DEPTH`, 16: sample buffer entries.
- `AW`, 4: buffer address width, `$clog2(DEPTH)`.
- `EPW`, 8: epoch counter width.
- `TGT_O`, 32: signed target for label 1 (O).
- `TGT_X`, -32: signed target for label 0 (X).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `wr_en` in 1: sample write strobe. Honoured only in IDLE.
- `wr_addr` in AW: sample index.
- `wr_x` in 16: sample pixels.
- `wr_label` in 1: 1 = O, 0 = X.
- `cfg_n` in AW+1: samples per epoch, range 0..DEPTH. Latched on `start`.
- `cfg_epochs` in EPW: epochs to run. Latched on `start`.
- `start` in 1: begin training. Honoured only in IDLE.
- `abort` in 1: synchronous stop. Returns the block to IDLE.
- `fwd_start` out 1: one-cycle request to the forward pass.
- `fwd_x` out 16: forward input. Held from FWD through LEARN.
- `fwd_done` in 1: forward result valid. Sampled only in WAIT.
- `fwd_y` in W signed: forward output.
- `learn` out 1: one-cycle update strobe.
- `x` out 16: equals `fwd_x`.
- `err` out W signed: registered error.
- `busy` out 1: asserted when state ≠ IDLE.
- `done` out 1: one-cycle pulse when all epochs complete.
- `epoch_cnt` out EPW: epochs completed.
- `correct_cnt` out AW+1: correct predictions in the current epoch.
- `epoch_pulse` out 1: one-cycle pulse at the end of each epoch.
- `last_correct` out AW+1: `correct_cnt` snapshot taken at `epoch_pulse`.

## Operation
States: IDLE, FWD, WAIT, ERR, LEARN, NEXT.

- **IDLE**
  - `wr_en` writes `{wr_label, wr_x}` into `buffer[wr_addr]`.
  - On `start`: latch `cfg_n` and `cfg_epochs`; clear `idx`, `epoch_cnt`, `correct_cnt`.
  - If `cfg_n == 0` or `cfg_epochs == 0`: pulse `done` next cycle and stay in IDLE.
  - Otherwise go to FWD.
  - If `wr_en` and `start` occur in the same cycle, the write lands first; that entry is used.
- **FWD**
  - `fwd_x` loads `buffer[idx].x`.
  - `fwd_start` = 1 for exactly this cycle.
  - Next state: WAIT.
- **WAIT**
  - Hold until `fwd_done`, then capture `y = fwd_y` and go to ERR.
  - No timeout.
- **ERR**
  - `target = label ? TGT_O : TGT_X`.
  - Compute `diff = target - y` at W+1 bits, then saturate to the W-bit range [-2^(W-1), 2^(W-1)-1] and register it into `err`.
  - A prediction is correct when `(y >= 0) == label`; if so, `correct_cnt++`.
  - If the saturated `err == 0`, skip LEARN and go to NEXT. Otherwise go to LEARN.
- **LEARN**
  - `learn` = 1 for one cycle.
  - `x` and `err` are stable throughout.
  - Next state: NEXT.
- **NEXT**
  - If `idx == n - 1`: pulse `epoch_pulse`, copy `last_correct = correct_cnt`, clear `correct_cnt`, `epoch_cnt++`, `idx = 0`.
    - If `epoch_cnt + 1 == epochs`: pulse `done` and go to IDLE.
    - Otherwise go to FWD.
  - Else: `idx++` and go to FWD.

Other rules:
- `abort`, in any non-IDLE state, forces IDLE on the next edge. `learn` and `fwd_start` must not assert in that cycle. Counters hold their values. Abort takes priority over every transition.
- `wr_en` outside IDLE is ignored; the buffer is unchanged.
- `start` outside IDLE is ignored.
- Buffer contents are not reset. Only the control state is reset.

## Timing
- Reset values:
  - state IDLE.
  - `fwd_start`, `learn`, `busy`, `done`, `epoch_pulse` = 0.
  - `fwd_x`, `x` = 0.
  - `err` = 0.
  - `epoch_cnt`, `correct_cnt`, `last_correct` = 0.
- All outputs are registered.
- `start` at edge t: `busy` and `fwd_start` are high from cycle t+1.
- Per sample: 1 (FWD) + k (WAIT, k ≥ 1) + 1 (ERR) + 1 (LEARN) + 1 (NEXT) = k + 4 cycles. The LEARN cycle is dropped when `err == 0`.
- `learn` rises the cycle after ERR.
- `fwd_done` asserted in the same cycle as `fwd_start` is ignored.
- The forward block's hidden activations must stay valid until the next `fwd_start`; the update block samples them under `learn`.
- `done` pulses in the same cycle as the final `epoch_pulse`. `busy` drops on the following cycle.

## Structure
- Shared package `mlp_pkg` holds:
  - W, FRAC, and HRAW_W = W + 5.
  - The state enum.
  - TGT_O and TGT_X.
  - A saturate-to-W function, reused by the forward and update blocks.
- Sub-module `mlp_sample_mem`: DEPTH × 17-bit register file with synchronous write and combinational read.
- The FSM, counters and error logic live in `mlp_train_ctrl`.

## Test plan
- **Basic loop.** Load 2 samples (x = 16'hF99F label 1, x = 16'h9669 label 0); `cfg_n = 2`, `cfg_epochs = 1`; forward model returns y = 10 then 5 with k = 3.
  - `learn` pulses twice: `err` = 22, then -37.
  - `correct_cnt` reaches 1; `last_correct` = 1.
  - `done` occurs 14 cycles after `start`.
- **Saturation.** Label 0, y = 127.
  - `diff` = -159, so `err` = -128.
  - Label 1, y = -128: `err` = 127.
- **Zero error.** y = TGT_O with label 1.
  - No `learn`, `correct_cnt++`, per-sample latency k + 3.
- **Abort.** Assert `abort` during WAIT, then during LEARN.
  - IDLE on the next cycle; no further `learn` or `fwd_start`.
  - `epoch_cnt` is unchanged.
- **Boundaries.**
  - `cfg_n = 0`: `done` one cycle after `start`, no `fwd_start`.
  - `wr_en` while `busy`: ignored.
  - `cfg_n = DEPTH`, `cfg_epochs = 3`: `idx` wraps 15 → 0, three `epoch_pulse`s, `epoch_cnt` = 3.
- **Reset mid-run.** Assert `rst_n = 0` during LEARN.
  - All outputs take their reset values next cycle.
  - Buffer contents are retained; a re-run after reset produces identical `err` values.
